// File: rtl/ttt_move_engine_if.sv
// rtl/ttt_move_engine_if.sv - key event inputs and board/turn/result outputs of the move engine
interface ttt_move_engine_if;
    logic        game_en;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [17:0] board;
    logic        turn_o;
    logic [1:0]  result;
    logic [3:0]  move_cnt;
    logic        move_ack;
    logic        move_nack;

    modport master (
        output game_en, key_valid, key_code,
        input  board, turn_o, result, move_cnt, move_ack, move_nack
    );

    modport slave (
        input  game_en, key_valid, key_code,
        output board, turn_o, result, move_cnt, move_ack, move_nack
    );
endinterface

// File: rtl/ttt_move_engine.sv
// rtl/ttt_move_engine.sv - tic-tac-toe move legality, turn order and win/draw detection
module ttt_move_engine #(
    parameter logic START_O = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    ttt_move_engine_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PLAY, CHECK, DONE} state_e;

    state_e      state_q;
    logic [17:0] board_q;
    logic        turn_q;
    logic [1:0]  result_q;
    logic [3:0]  cnt_q;
    logic        ack_q;
    logic        nack_q;

    logic        is_cell;
    logic        is_star;
    logic [1:0]  mover;
    logic        cell_free;
    logic [17:0] board_d;
    logic        win;

    // Cell k lives at bits [19-2k:18-2k]; three cells equal to side s form a line.
    function automatic logic line3(input logic [17:0] b, input int a, input int c,
                                   input int d, input logic [1:0] s);
        return (b[18-2*a +: 2] == s) && (b[18-2*c +: 2] == s) && (b[18-2*d +: 2] == s);
    endfunction

    assign is_cell = bus.key_valid && (bus.key_code >= 4'd1) && (bus.key_code <= 4'd9);
    assign is_star = bus.key_valid && (bus.key_code == 4'd10);
    assign mover   = turn_q ? 2'b10 : 2'b01;

    always_comb begin
        cell_free = 1'b0;
        board_d   = board_q;
        for (int k = 1; k <= 9; k++) begin
            if (bus.key_code == 4'(k)) begin
                cell_free             = (board_q[18-2*k +: 2] == 2'b00);
                board_d[18-2*k +: 2]  = mover;
            end
        end
    end

    // Only the side that just moved can have completed a line.
    assign win = line3(board_q, 1, 2, 3, mover) | line3(board_q, 4, 5, 6, mover) |
                 line3(board_q, 7, 8, 9, mover) | line3(board_q, 1, 4, 7, mover) |
                 line3(board_q, 2, 5, 8, mover) | line3(board_q, 3, 6, 9, mover) |
                 line3(board_q, 1, 5, 9, mover) | line3(board_q, 3, 5, 7, mover);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            board_q  <= '0;
            turn_q   <= START_O;
            result_q <= 2'b00;
            cnt_q    <= 4'd0;
            ack_q    <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            nack_q <= 1'b0;
            if (!bus.game_en) begin
                state_q  <= IDLE;
                board_q  <= '0;
                turn_q   <= START_O;
                result_q <= 2'b00;
                cnt_q    <= 4'd0;
            end else begin
                case (state_q)
                    IDLE: state_q <= PLAY;
                    PLAY: begin
                        if (is_cell) begin
                            if (cell_free) begin
                                board_q <= board_d;
                                cnt_q   <= cnt_q + 4'd1;
                                ack_q   <= 1'b1;
                                state_q <= CHECK;
                            end else begin
                                nack_q  <= 1'b1;
                            end
                        end else if (is_star) begin
                            board_q  <= '0;
                            turn_q   <= START_O;
                            result_q <= 2'b00;
                            cnt_q    <= 4'd0;
                        end
                    end
                    CHECK: begin
                        nack_q <= is_cell;
                        if (win) begin
                            result_q <= mover;
                            state_q  <= DONE;
                        end else if (cnt_q == 4'd9) begin
                            result_q <= 2'b11;
                            state_q  <= DONE;
                        end else begin
                            turn_q   <= ~turn_q;
                            state_q  <= PLAY;
                        end
                    end
                    DONE: begin
                        if (is_cell) begin
                            nack_q <= 1'b1;
                        end else if (is_star) begin
                            board_q  <= '0;
                            turn_q   <= START_O;
                            result_q <= 2'b00;
                            cnt_q    <= 4'd0;
                            state_q  <= PLAY;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.board     = board_q;
    assign bus.turn_o    = turn_q;
    assign bus.result    = result_q;
    assign bus.move_cnt  = cnt_q;
    assign bus.move_ack  = ack_q;
    assign bus.move_nack = nack_q;

endmodule

// File: tb/tb_ttt_move_engine.sv
// tb/tb_ttt_move_engine.sv - randomized and directed checks of ttt_move_engine against a game model
module tb_ttt_move_engine;

    localparam logic START = 1'b0;
    localparam int P_IDLE = 0, P_PLAY = 1, P_CHECK = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ttt_move_engine_if bus();

    ttt_move_engine #(.START_O(START)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ack_seen = 0;

    int m_cell [1:9];
    int m_turn, m_res, m_cnt, m_ack, m_nack, m_phase;
    int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                         '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [17:0] m_board();
        logic [17:0] r = '0;
        for (int k = 1; k <= 9; k++) r[18-2*k +: 2] = 2'(m_cell[k]);
        return r;
    endfunction

    function automatic bit m_wins(input int s);
        for (int l = 0; l < 8; l++)
            if (m_cell[lines[l][0]] == s && m_cell[lines[l][1]] == s && m_cell[lines[l][2]] == s)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_clear();
        for (int k = 1; k <= 9; k++) m_cell[k] = 0;
        m_turn = int'(START);
        m_res  = 0;
        m_cnt  = 0;
    endtask

    task automatic m_reset();
        m_clear();
        m_ack   = 0;
        m_nack  = 0;
        m_phase = P_IDLE;
    endtask

    task automatic m_step(input int ge, input int kv, input int kc);
        bit cell_key;
        int side;
        cell_key = (kv != 0) && kc >= 1 && kc <= 9;
        side     = m_turn + 1;
        m_ack    = 0;
        m_nack   = 0;
        if (ge == 0) begin
            m_reset();
        end else begin
            case (m_phase)
                P_IDLE: m_phase = P_PLAY;
                P_PLAY: begin
                    if (cell_key) begin
                        if (m_cell[kc] == 0) begin
                            m_cell[kc] = side;
                            m_cnt++;
                            m_ack   = 1;
                            m_phase = P_CHECK;
                        end else begin
                            m_nack = 1;
                        end
                    end else if (kv != 0 && kc == 10) begin
                        m_clear();
                    end
                end
                P_CHECK: begin
                    m_nack = cell_key ? 1 : 0;
                    if (m_wins(side)) begin
                        m_res   = side;
                        m_phase = P_DONE;
                    end else if (m_cnt == 9) begin
                        m_res   = 3;
                        m_phase = P_DONE;
                    end else begin
                        m_turn  = 1 - m_turn;
                        m_phase = P_PLAY;
                    end
                end
                default: begin
                    if (cell_key) m_nack = 1;
                    else if (kv != 0 && kc == 10) begin
                        m_clear();
                        m_phase = P_PLAY;
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check("board",    32'(bus.board),     32'(m_board()));
        check("turn_o",   32'(bus.turn_o),    32'(m_turn));
        check("result",   32'(bus.result),    32'(m_res));
        check("move_cnt", 32'(bus.move_cnt),  32'(m_cnt));
        check("ack",      32'(bus.move_ack),  32'(m_ack));
        check("nack",     32'(bus.move_nack), 32'(m_nack));
    endtask

    task automatic step(input int ge, input int kv, input int kc);
        bus.game_en   = 1'(ge);
        bus.key_valid = 1'(kv);
        bus.key_code  = 4'(kc);
        @(posedge clk);
        #1;
        m_step(ge, kv, kc);
        if (bus.move_ack) ack_seen++;
        compare_all();
    endtask

    task automatic key(input int c);
        step(1, 1, c);
        step(1, 0, 0);
    endtask

    initial begin
        int seq_draw [9] = '{1,2,3,5,4,6,8,7,9};
        int seq_diag [9] = '{1,2,3,4,5,6,7,9,8};
        int r, ge, kv, kc;

        rst = 1'b0;
        bus.game_en = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code = 4'd0;
        @(posedge clk);
        #1;
        m_reset();
        compare_all();
        rst = 1'b1;
        step(1, 0, 0);

        // five-move X win on the top row
        ack_seen = 0;
        key(1); key(4); key(2); key(5); key(3);
        check("win_acks",   32'(ack_seen),   32'd5);
        check("win_board",  32'(bus.board),  32'(18'b01_01_01_10_10_00_00_00_00));
        check("win_result", 32'(bus.result), 32'd1);

        // cell key after a win is rejected, board frozen
        step(1, 1, 6);
        check("done_nack",  32'(bus.move_nack), 32'd1);
        check("done_board", 32'(bus.board), 32'(18'b01_01_01_10_10_00_00_00_00));
        step(1, 0, 0);
        key(10);
        check("rst_board",  32'(bus.board),    32'd0);
        check("rst_result", 32'(bus.result),   32'd0);
        check("rst_turn",   32'(bus.turn_o),   32'(START));
        check("rst_cnt",    32'(bus.move_cnt), 32'd0);

        // occupied cell
        key(5);
        step(1, 1, 5);
        check("occ_nack",  32'(bus.move_nack), 32'd1);
        check("occ_cell5", 32'(bus.board[9:8]), 32'd1);
        check("occ_cnt",   32'(bus.move_cnt), 32'd1);
        check("occ_turn",  32'(bus.turn_o), 32'd1);
        step(1, 0, 0);

        key(10);
        for (int i = 0; i < 9; i++) key(seq_draw[i]);
        check("draw_cnt",    32'(bus.move_cnt), 32'd9);
        check("draw_result", 32'(bus.result), 32'd3);

        key(10);
        for (int i = 0; i < 9; i++) key(seq_diag[i]);
        check("xwin_result", 32'(bus.result), 32'd1);

        // key landing in the CHECK cycle is dropped
        key(10);
        step(1, 1, 1);
        step(1, 1, 2);
        check("chk_nack", 32'(bus.move_nack), 32'd1);
        step(1, 0, 0);
        check("chk_board", 32'(bus.board), 32'(18'b01_00_00_00_00_00_00_00_00));

        // game_en drop beats a simultaneous key
        key(5);
        step(0, 1, 7);
        check("ge_board", 32'(bus.board), 32'd0);
        check("ge_ack",   32'(bus.move_ack), 32'd0);
        step(1, 0, 0);

        // asynchronous reset in the middle of CHECK
        step(1, 1, 3);
        #3;
        rst = 1'b0;
        #1;
        m_reset();
        check("arst_board",  32'(bus.board),    32'd0);
        check("arst_cnt",    32'(bus.move_cnt), 32'd0);
        check("arst_ack",    32'(bus.move_ack), 32'd0);
        check("arst_turn",   32'(bus.turn_o),   32'(START));
        @(posedge clk);
        #1;
        rst = 1'b1;
        compare_all();

        for (int i = 0; i < 4000; i++) begin
            ge = ($urandom % 64 != 0) ? 1 : 0;
            kv = int'($urandom % 2);
            r  = int'($urandom % 20);
            if (r < 15)      kc = 1 + int'($urandom % 9);
            else if (r < 17) kc = 10;
            else if (r < 18) kc = 0;
            else             kc = int'($urandom_range(11, 15));
            step(ge, kv, kc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
